// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback stage: FS encodings, instruction
// field positions and the issue FSM state type.
package alu_pkg;

    localparam logic [3:0] FS_ADD  = 4'b0000;
    localparam logic [3:0] FS_SUB  = 4'b0001;
    localparam logic [3:0] FS_AND  = 4'b0010;
    localparam logic [3:0] FS_OR   = 4'b0011;
    localparam logic [3:0] FS_XOR  = 4'b0100;
    localparam logic [3:0] FS_NOT  = 4'b0101;
    localparam logic [3:0] FS_SHL  = 4'b0110;
    localparam logic [3:0] FS_SHR  = 4'b0111;
    localparam logic [3:0] FS_INC  = 4'b1011;
    localparam logic [3:0] FS_DEC  = 4'b1100;
    localparam logic [3:0] FS_PASS = 4'b1111;

    localparam int unsigned FS_MSB = 15;
    localparam int unsigned FS_LSB = 12;
    localparam int unsigned RD_MSB = 11;
    localparam int unsigned RD_LSB = 9;
    localparam int unsigned RA_MSB = 8;
    localparam int unsigned RA_LSB = 6;
    localparam int unsigned RB_MSB = 5;
    localparam int unsigned RB_LSB = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic fs_reserved(input logic [3:0] fs);
        return (fs == 4'b1000) || (fs == 4'b1001) || (fs == 4'b1010) ||
               (fs == 4'b1101) || (fs == 4'b1110);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREG x W register file: two operand read ports, one debug read port and a single
// write port. Entry 0 always reads as zero and ignores writes.
module alu_regfile #(
    parameter int unsigned NREG = 8,
    parameter int unsigned W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_we,
    input  logic [$clog2(NREG)-1:0]  i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(NREG)-1:0]  i_ra_addr,
    output logic [W-1:0]             o_ra_data,
    input  logic [$clog2(NREG)-1:0]  i_rb_addr,
    output logic [W-1:0]             o_rb_data,
    input  logic [$clog2(NREG)-1:0]  i_dbg_addr,
    output logic [W-1:0]             o_dbg_data
);

    logic [W-1:0] r_rf [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_rf[i_waddr] <= i_wdata;
        end
    end

    assign o_ra_data  = (i_ra_addr  == '0) ? '0 : r_rf[i_ra_addr];
    assign o_rb_data  = (i_rb_addr  == '0) ? '0 : r_rf[i_rb_addr];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_rf[i_dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue/writeback stage ahead of the 16-bit ALU: reads operands, drives A/B/FS from
// registers, then writes the captured result back and tracks a zero flag.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int unsigned NREG = 8,
    parameter int unsigned W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     instr_valid,
    input  logic [15:0]              instr,
    output logic                     instr_ready,
    input  logic                     wr_en,
    input  logic [$clog2(NREG)-1:0]  wr_addr,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             alu_a,
    output logic [W-1:0]             alu_b,
    output logic [3:0]               alu_fs,
    input  logic [W-1:0]             alu_result,
    output logic                     done,
    output logic                     illegal,
    output logic [W-1:0]             result_q,
    output logic                     zero_flag,
    input  logic [$clog2(NREG)-1:0]  dbg_addr,
    output logic [W-1:0]             dbg_data
);

    localparam int unsigned AW = $clog2(NREG);

    state_e        r_state;
    state_e        w_state_next;
    logic [W-1:0]  r_alu_a;
    logic [W-1:0]  r_alu_b;
    logic [3:0]    r_alu_fs;
    logic [AW-1:0] r_rd;
    logic [W-1:0]  r_result;
    logic          r_zero;

    logic          w_accept;
    logic          w_wb_legal;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [W-1:0]  w_wdata;
    logic [W-1:0]  w_ra_data;
    logic [W-1:0]  w_rb_data;
    logic          w_unused_instr;

    assign w_unused_instr = ^instr[2:0];

    assign w_accept   = (r_state == IDLE) && instr_valid;
    assign w_wb_legal = (r_state == EXEC) && !fs_reserved(r_alu_fs);

    // Host and writeback never share a cycle: host only in IDLE, writeback only in EXEC.
    assign w_we    = ((r_state == IDLE) && wr_en) || (w_wb_legal && (r_rd != '0));
    assign w_waddr = (r_state == IDLE) ? wr_addr : r_rd;
    assign w_wdata = (r_state == IDLE) ? wr_data : alu_result;

    alu_regfile #(
        .NREG (NREG),
        .W    (W)
    ) u_regfile (
        .clk        (clk),
        .reset      (reset),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wdata    (w_wdata),
        .i_ra_addr  (instr[RA_MSB:RA_LSB]),
        .o_ra_data  (w_ra_data),
        .i_rb_addr  (instr[RB_MSB:RB_LSB]),
        .o_rb_data  (w_rb_data),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (instr_valid) w_state_next = EXEC;
            EXEC:    w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_fs <= '0;
            r_rd     <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_alu_a  <= w_ra_data;
                r_alu_b  <= w_rb_data;
                r_alu_fs <= instr[FS_MSB:FS_LSB];
                r_rd     <= instr[RD_MSB:RD_LSB];
            end
            if (w_wb_legal) begin
                r_result <= alu_result;
                r_zero   <= (alu_result == '0);
            end
        end
    end

    assign instr_ready = (r_state == IDLE);
    assign done        = (r_state == DONE);
    assign illegal     = (r_state == DONE) && fs_reserved(r_alu_fs);
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_fs      = r_alu_fs;
    assign result_q    = r_result;
    assign zero_flag   = r_zero;

endmodule
